// File: rtl/switch_request_unit.sv
`default_nettype none
// ============================================================================
// Module   : switch_request_unit
// Purpose  : Per-input-port VC selection and switch-request FSM for a router;
//            optional request aging enabled by macro SA_REQ_AGE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module switch_request_unit #(
    parameter int NUM_PORTS = 4,
    parameter int NUM_VCS   = 4,
    parameter int AGE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_VCS-1:0]   vc_valid         [NUM_PORTS],
    input  logic [NUM_PORTS-1:0] vc_out_port      [NUM_PORTS][NUM_VCS],
    input  logic [NUM_PORTS-1:0] out_credit_avail,
    input  logic [NUM_PORTS-1:0] allocated_ports  [NUM_PORTS],
    output logic [NUM_PORTS-1:0] port_requests    [NUM_PORTS],
    output logic [NUM_VCS-1:0]   vc_pop           [NUM_PORTS],
    output logic [NUM_PORTS-1:0] xbar_sel         [NUM_PORTS]
);

    localparam int VCW = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
`ifdef SA_REQ_AGE_EN
    localparam int AGW = $clog2(AGE_LIMIT + 1);
`endif

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    // Holds off new requests until one full edge has passed after reset release.
    logic started;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            started <= 1'b0;
        end else begin
            started <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        state_t               state_q, state_d;
        logic [VCW-1:0]       vc_q, vc_d, ptr_q, ptr_d, vc_inc, pick;
        logic [NUM_PORTS-1:0] port_q, port_d;
        logic [NUM_PORTS-1:0] req_q, req_d, sel_q, sel_d;
        logic [NUM_VCS-1:0]   pop_q, pop_d, elig;
        logic                 found, grant, withdraw;
`ifdef SA_REQ_AGE_EN
        logic [AGW-1:0]       age_q, age_d;
`endif

        always_comb begin
            elig = '0;
            for (int v = 0; v < NUM_VCS; v++) begin
                elig[v] = vc_valid[i][v] && (|(vc_out_port[i][v] & out_credit_avail));
            end
        end

        // Round-robin search starting at ptr_q; the first hit wins.
        always_comb begin
            int t;
            found = 1'b0;
            pick  = '0;
            for (int k = 0; k < NUM_VCS; k++) begin
                t = int'(ptr_q) + k;
                if (t >= NUM_VCS) begin
                    t = t - NUM_VCS;
                end
                if (!found && elig[t]) begin
                    found = 1'b1;
                    pick  = VCW'(t);
                end
            end
        end

        assign vc_inc   = (vc_q == VCW'(NUM_VCS - 1)) ? '0 : vc_q + 1'b1;
        assign grant    = (allocated_ports[i] == port_q);
        assign withdraw = !vc_valid[i][vc_q] || !(|(port_q & out_credit_avail));

        always_comb begin
            state_d = state_q;
            vc_d    = vc_q;
            port_d  = port_q;
            ptr_d   = ptr_q;
            req_d   = '0;
            pop_d   = '0;
            sel_d   = '0;
`ifdef SA_REQ_AGE_EN
            age_d   = age_q;
`endif
            case (state_q)
                S_IDLE: begin
                    if (started && found) begin
                        state_d = S_REQ;
                        vc_d    = pick;
                        port_d  = vc_out_port[i][pick];
                        req_d   = vc_out_port[i][pick];
`ifdef SA_REQ_AGE_EN
                        age_d   = '0;
`endif
                    end
                end
                S_REQ: begin
                    if (grant) begin
                        state_d     = S_IDLE;
                        pop_d[vc_q] = 1'b1;
                        sel_d       = port_q;
                        ptr_d       = vc_inc;
`ifdef SA_REQ_AGE_EN
                        age_d       = '0;
`endif
                    end else if (withdraw) begin
                        state_d = S_IDLE;
`ifdef SA_REQ_AGE_EN
                        age_d   = '0;
                    end else if (age_q == AGW'(AGE_LIMIT - 1)) begin
                        // Starved request: give the other VCs a turn.
                        state_d = S_IDLE;
                        ptr_d   = vc_inc;
                        age_d   = '0;
                    end else begin
                        req_d   = port_q;
                        age_d   = age_q + 1'b1;
                    end
`else
                    end else begin
                        req_d   = port_q;
                    end
`endif
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= S_IDLE;
                vc_q    <= '0;
                port_q  <= '0;
                ptr_q   <= '0;
                req_q   <= '0;
                pop_q   <= '0;
                sel_q   <= '0;
`ifdef SA_REQ_AGE_EN
                age_q   <= '0;
`endif
            end else begin
                state_q <= state_d;
                vc_q    <= vc_d;
                port_q  <= port_d;
                ptr_q   <= ptr_d;
                req_q   <= req_d;
                pop_q   <= pop_d;
                sel_q   <= sel_d;
`ifdef SA_REQ_AGE_EN
                age_q   <= age_d;
`endif
            end
        end

        assign port_requests[i] = req_q;
        assign vc_pop[i]        = pop_q;
        assign xbar_sel[i]      = sel_q;
    end

endmodule
`default_nettype wire

// File: doc/switch_request_unit.md
SWITCH_REQUEST_UNIT -- requirements
Module: switch_request_unit

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of router input and output ports.
REQ-002 Parameter NUM_VCS, default 4: virtual channels per input port.
REQ-003 Parameter AGE_LIMIT, default 8: cycles a request may wait ungranted; used only under SA_REQ_AGE_EN.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 vc_valid[NUM_PORTS]  input  NUM_VCS  per input port, per-VC bit: head flit present and output VC allocated.
REQ-007 vc_out_port[NUM_PORTS][NUM_VCS]  input  NUM_PORTS  one-hot output port of each VC's head flit.
REQ-008 out_credit_avail  input  NUM_PORTS  bit j set: downstream of output port j has at least one credit.
REQ-009 allocated_ports[NUM_PORTS]  input  NUM_PORTS  grants returned by the switch allocator, indexed by input port.
REQ-010 port_requests[NUM_PORTS]  output  NUM_PORTS  registered, one-hot-or-zero switch request per input port.
REQ-011 vc_pop[NUM_PORTS]  output  NUM_VCS  registered, one-hot-or-zero single-cycle pulse: pop the head flit of the granted VC.
REQ-012 xbar_sel[NUM_PORTS]  output  NUM_PORTS  registered, one-hot crossbar select; valid in the same cycle as vc_pop.

Function
REQ-013 Each input port shall run an independent FSM with states IDLE and REQ.
REQ-014 VC v is eligible when vc_valid[i][v]=1 and out_credit_avail has the bit of vc_out_port[i][v] set.
REQ-015 IDLE: if any VC is eligible, select by round-robin from pointer rr_ptr[i], latch the VC index and its output port, and enter REQ; port_requests[i] shall assert on the following cycle.
REQ-016 REQ: port_requests[i] shall equal the latched one-hot port and hold stable until grant, withdrawal or reset.
REQ-017 Grant: in REQ with allocated_ports[i] equal to the latched port, the next cycle shall have vc_pop[i] pulse the latched VC, xbar_sel[i] set to the latched port, and port_requests[i] zero. rr_ptr[i] shall become latched VC+1, modulo NUM_VCS. The FSM shall return to IDLE.
REQ-018 Throughput: at most one grant per input port every 2 cycles; after a grant, the earliest new request is 2 cycles later.
REQ-019 Withdrawal: in REQ, if the latched VC's vc_valid drops or its out_credit_avail bit drops without a grant that cycle, the request shall clear the next cycle, with no pop; FSM to IDLE; rr_ptr unchanged.
REQ-020 Grant and withdrawal in the same cycle: the grant wins.
REQ-021 allocated_ports[i] nonzero while in IDLE, or not equal to the latched port, shall be ignored: no pop, no state change.
REQ-022 rr_ptr wraps NUM_VCS-1 to 0; index width is $clog2(NUM_VCS), minimum 1.
REQ-023 vc_pop[i] and xbar_sel[i] shall be zero in every cycle other than a post-grant cycle.

Reset
REQ-024 On reset assertion, immediately and independent of clk: all FSMs to IDLE; rr_ptr to 0; port_requests, vc_pop and xbar_sel to zero; age counters to 0.
REQ-025 Reset mid-REQ shall drop the request with no pop; the first request after deassertion shall appear no earlier than the second rising edge.

Configuration
REQ-026 Macro SA_REQ_AGE_EN defined: a per-port counter shall count REQ cycles without grant.
REQ-027 Under SA_REQ_AGE_EN, when the counter reaches AGE_LIMIT: request withdrawn; rr_ptr set to latched VC+1; FSM to IDLE; counter cleared. The counter also clears on grant or withdrawal.
REQ-028 SA_REQ_AGE_EN undefined: no counter logic; requests are held indefinitely until grant or withdrawal.

Verification
REQ-029 Port 0, VC 2 valid to port 1, credits all 1; grant returned 1 cycle after the request -> port_requests[0]=0010 at t+1, vc_pop[0]=0100 and xbar_sel[0]=0010 at t+3, then request 0.
REQ-030 Port 1, VCs 0 and 3 valid, always granted -> pops alternate VC0, VC3, VC0, one pop every 2 cycles.
REQ-031 Request pending, out_credit_avail bit cleared, no grant -> port_requests zero next cycle, no vc_pop, same VC re-requested when the credit returns.
REQ-032 Mismatched grant (allocated_ports[2]=0100 while 0001 is requested) -> no pop, request held; grant while IDLE -> ignored.
REQ-033 Reset asserted between clock edges while in REQ -> outputs zero before the next edge; after deassertion, rr_ptr=0 and VC 0 is selected first.
REQ-034 SA_REQ_AGE_EN with AGE_LIMIT=8, never granted, VCs 1 and 2 valid -> VC1 request withdrawn after 8 cycles, VC2 requested next; without the macro, VC1 is held indefinitely.
